uart_rx_param: RTL and testbench

Parametrised successor to the fixed 8N1 UART receiver. It supports configurable baud and clock rates, 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. Reception uses oversampled, majority-voted sampling with false-start rejection, and the block reports framing, parity, overrun and break conditions. A one-entry output register with a valid/ready handshake feeds the downstream FIFO or register interface.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_param.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states and the baud divider calculation.
// The parametrised transmitter reuses this package.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } rx_state_e;

    // Rounded clk / (baud * os), so the tick rate error stays within half a clock.
    function automatic int calc_div(input longint clk, input longint baud, input longint os);
        longint den;
        den = baud * os;
        return int'((clk + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider emitting a one-cycle tick every DIV clocks; restart realigns the phase.
// Shared by the receiver (oversampled) and the transmitter (one tick per bit).
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clock,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled 2-of-3 majority sampling, optional parity, 1-2 stop bits,
// error/break reporting and a one-entry valid/ready output register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 break_det
);

    // Handshake: a word transfers on any clock edge where rx_valid && rx_ready; rx_data and the
    // error flags are stable while rx_valid is high, and a new word may load on the transfer edge.

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    if (DIV < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_rx_param: illegal parameter combination");
    end

    rx_state_e            state, state_nx;
    logic                 rx_s1, rx_s2, rx_prev;
    logic                 tick, start_edge, samp_done, maj;
    logic [TW-1:0]        tick_cnt;
    logic [1:0]           votes;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 all_zero, perr_acc, ferr_acc, par_x;
    logic                 last_data, last_stop, brk_enter, frame_done, ferr_fin;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Only a genuine 1->0 transition starts a frame, so a line left low by a bad stop bit is ignored.
    assign start_edge = (state == IDLE) && rx_prev && !rx_s2;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clock   (clock),
        .rst     (rst),
        .restart (start_edge),
        .tick    (tick)
    );

    // The third vote is the live sample; every decision is made on this mid-bit strobe.
    assign samp_done  = tick && (tick_cnt == T_S2);
    assign maj        = (votes[0] & votes[1]) | (votes[0] & rx_s2) | (votes[1] & rx_s2);
    assign last_data  = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop  = (bit_cnt == 4'(STOP_BITS - 1));
    assign brk_enter  = (state == STOP) && samp_done && (bit_cnt == 4'd0) && all_zero && !maj;
    assign frame_done = (state == STOP) && samp_done && last_stop && !brk_enter;
    assign ferr_fin   = ferr_acc | ~maj;
    assign par_x      = (^shreg) ^ maj;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:             if (start_edge) state_nx = START;
            START:            if (samp_done) state_nx = maj ? IDLE : DATA;
            DATA:             if (samp_done && last_data)
                                  state_nx = (PARITY != 0) ? uart_pkg::PARITY : STOP;
            uart_pkg::PARITY: if (samp_done) state_nx = STOP;
            STOP:             if (brk_enter) state_nx = BRK;
                              else if (frame_done) state_nx = IDLE;
            BRK:              if (rx_s2) state_nx = IDLE;
            default:          state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            votes    <= 2'b11;
            bit_cnt  <= '0;
            shreg    <= '0;
            all_zero <= 1'b0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            if (start_edge) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
            end
            if (tick && tick_cnt == T_S0) votes[0] <= rx_s2;
            if (tick && tick_cnt == T_S1) votes[1] <= rx_s2;

            if (start_edge) begin
                bit_cnt  <= '0;
                all_zero <= 1'b1;
                perr_acc <= 1'b0;
                ferr_acc <= 1'b0;
            end else if (samp_done) begin
                case (state)
                    DATA: begin
                        shreg    <= {maj, shreg[DATA_BITS-1:1]};
                        all_zero <= all_zero & ~maj;
                        bit_cnt  <= last_data ? 4'd0 : bit_cnt + 4'd1;
                    end
                    uart_pkg::PARITY: begin
                        perr_acc <= (PARITY == int'(PAR_ODD)) ? ~par_x : par_x;
                        all_zero <= all_zero & ~maj;
                    end
                    STOP: begin
                        ferr_acc <= ferr_acc | ~maj;
                        bit_cnt  <= bit_cnt + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A frame finishing on the same edge as a transfer refills the register without an overrun.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            break_det   <= brk_enter;
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                parity_err <= perr_acc;
                frame_err  <= ferr_fin;
            end else if (frame_done) begin
                overrun_err <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed plus randomised bench for uart_rx_param across four configurations
// (default 8N1, fast 8N1, 7E2 and 5O1), checked against a frame-level reference model.
module tb_uart_rx_param;

    logic       clock = 1'b0;
    logic       rst;
    logic [3:0] rx_v;
    logic [3:0] rdy_v;

    always #5 clock = ~clock;

    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic [4:0] data_d;
    logic valid_a, valid_b, valid_c, valid_d;
    logic perr_a, perr_b, perr_c, perr_d;
    logic ferr_a, ferr_b, ferr_c, ferr_d;
    logic ovr_a, ovr_b, ovr_c, ovr_d;
    logic brk_a, brk_b, brk_c, brk_d;

    // Instance 0: default parameters (DIV 54 -> 864 clk/bit, line driven at 868 clk/bit)
    uart_rx_param dut_a (
        .clock(clock), .rst(rst), .rx(rx_v[0]), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(rdy_v[0]), .parity_err(perr_a), .frame_err(ferr_a),
        .overrun_err(ovr_a), .break_det(brk_a));

    // Instance 1: 8N1, DIV 2, 32 clk/bit
    uart_rx_param #(.CLK_FREQ(3_686_400)) dut_b (
        .clock(clock), .rst(rst), .rx(rx_v[1]), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(rdy_v[1]), .parity_err(perr_b), .frame_err(ferr_b),
        .overrun_err(ovr_b), .break_det(brk_b));

    // Instance 2: 7 data bits, even parity, 2 stop bits, OVERSAMPLE 8, DIV 3, 24 clk/bit
    uart_rx_param #(.CLK_FREQ(2_764_800), .OVERSAMPLE(8), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(2)) dut_c (
        .clock(clock), .rst(rst), .rx(rx_v[2]), .rx_data(data_c), .rx_valid(valid_c),
        .rx_ready(rdy_v[2]), .parity_err(perr_c), .frame_err(ferr_c),
        .overrun_err(ovr_c), .break_det(brk_c));

    // Instance 3: 5 data bits, odd parity, 1 stop bit, DIV 1, 16 clk/bit
    uart_rx_param #(.CLK_FREQ(1_843_200), .DATA_BITS(5), .PARITY(1)) dut_d (
        .clock(clock), .rst(rst), .rx(rx_v[3]), .rx_data(data_d), .rx_valid(valid_d),
        .rx_ready(rdy_v[3]), .parity_err(perr_d), .frame_err(ferr_d),
        .overrun_err(ovr_d), .break_det(brk_d));

    int cpb[4]   = '{868, 32, 24, 16};
    int nbits[4] = '{8, 8, 7, 5};
    int par[4]   = '{0, 0, 2, 1};
    int nstop[4] = '{1, 1, 2, 1};

    int n_vec = 0;
    int n_err = 0;

    // Records are {inst[1:0], parity_err, frame_err, data[8:0]}
    logic [12:0] exp_q[$];
    logic [12:0] obs_q[$];
    int          ovr_cnt[4] = '{0, 0, 0, 0};
    int          brk_cnt[4] = '{0, 0, 0, 0};

    // {overrun, break, valid, parity_err, frame_err, data[8:0]}
    function automatic logic [13:0] out_of(input int inst);
        case (inst)
            0:       return {ovr_a, brk_a, valid_a, perr_a, ferr_a, 1'b0, data_a};
            1:       return {ovr_b, brk_b, valid_b, perr_b, ferr_b, 1'b0, data_b};
            2:       return {ovr_c, brk_c, valid_c, perr_c, ferr_c, 2'b0, data_c};
            default: return {ovr_d, brk_d, valid_d, perr_d, ferr_d, 4'b0, data_d};
        endcase
    endfunction

    always @(negedge clock) begin : monitor
        logic [13:0] o;
        for (int i = 0; i < 4; i++) begin
            o = out_of(i);
            if (o[11] && rdy_v[i]) obs_q.push_back({2'(i), o[10:0]});
            if (o[13]) ovr_cnt[i]++;
            if (o[12]) brk_cnt[i]++;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input int inst, input logic b, input int ncyc);
        rx_v[inst] = b;
        tick_wait(ncyc);
    endtask

    task automatic send_frame(input int inst, input logic [8:0] d, input logic pbit, input logic s1);
        drive_bit(inst, 1'b0, cpb[inst]);
        for (int i = 0; i < nbits[inst]; i++) drive_bit(inst, d[i], cpb[inst]);
        if (par[inst] != 0) drive_bit(inst, pbit, cpb[inst]);
        drive_bit(inst, s1, cpb[inst]);
        if (nstop[inst] == 2) drive_bit(inst, 1'b1, cpb[inst]);
        rx_v[inst] = 1'b1;
    endtask

    // Frame-level reference: what a receiver must report for the serial bits that were sent.
    function automatic logic [12:0] model(input int inst, input logic [8:0] d, input logic pbit,
                                          input logic s1, output logic brk);
        logic [8:0] dm;
        int         ones;
        logic       perr;
        dm   = d & ((9'd1 << nbits[inst]) - 9'd1);
        ones = $countones(dm) + ((par[inst] != 0 && pbit) ? 1 : 0);
        if (par[inst] == 2)      perr = (ones % 2) == 1;
        else if (par[inst] == 1) perr = (ones % 2) == 0;
        else                     perr = 1'b0;
        brk = (dm == 9'd0) && (par[inst] == 0 || !pbit) && !s1;
        return {2'(inst), perr, !s1, dm};
    endfunction

    task automatic send_and_check(input int inst, input logic [8:0] d, input logic pbit,
                                  input logic s1);
        logic        brk;
        logic [12:0] e;
        int          b0;
        e  = model(inst, d, pbit, s1, brk);
        b0 = brk_cnt[inst];
        if (!brk) exp_q.push_back(e);
        send_frame(inst, d, pbit, s1);
        if (!s1) drive_bit(inst, 1'b1, cpb[inst]);
        tick_wait(4);
        @(negedge clock);
        if (brk) begin
            chk("break_pulse", 32'(brk_cnt[inst] - b0), 1);
            chk("break_no_word", 32'(obs_q.size()), 0);
        end else begin
            chk("word_count", 32'(obs_q.size()), 1);
            if (obs_q.size() > 0) chk("word", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
            else void'(exp_q.pop_front());
            chk("no_break", 32'(brk_cnt[inst] - b0), 0);
        end
        obs_q.delete();
        tick_wait($urandom_range(0, cpb[inst]));
    endtask

    initial begin : stimulus
        logic [12:0] e;
        logic        brk;
        int          o0, b0;

        rst   = 1'b0;
        rx_v  = 4'hF;
        rdy_v = 4'hF;
        tick_wait(5);
        rst = 1'b1;
        tick_wait(3);
        @(negedge clock);
        for (int i = 0; i < 4; i++) chk("reset_outputs", 32'(out_of(i)), 0);

        // Default configuration, two clean bytes
        send_and_check(0, 9'hA5, 1'b0, 1'b1);
        send_and_check(0, 9'h3C, 1'b0, 1'b1);

        // 7E2: wrong then correct parity bit
        send_and_check(2, 9'h3C, 1'b1, 1'b1);
        send_and_check(2, 9'h3C, 1'b0, 1'b1);

        // Stop bit low for one bit time on non-zero data: framing error, no break
        send_and_check(1, 9'h55, 1'b0, 1'b0);

        // Short low glitch on the default instance, then a good byte
        tick_wait(1);
        rx_v[0] = 1'b0;
        tick_wait(200);
        rx_v[0] = 1'b1;
        tick_wait(cpb[0]);
        @(negedge clock);
        chk("glitch_no_word", 32'(obs_q.size()), 0);
        chk("glitch_idle", 32'(dut_a.state), 32'(uart_pkg::IDLE));
        send_and_check(0, 9'h81, 1'b0, 1'b1);

        // Overrun: consumer stalled across two back-to-back frames
        tick_wait(1);
        rdy_v[1] = 1'b0;
        o0 = ovr_cnt[1];
        e  = model(1, 9'h11, 1'b0, 1'b1, brk);
        exp_q.push_back(e);
        send_frame(1, 9'h11, 1'b0, 1'b1);
        send_frame(1, 9'h22, 1'b0, 1'b1);
        tick_wait(4);
        @(negedge clock);
        chk("overrun_pulses", 32'(ovr_cnt[1] - o0), 1);
        chk("held_data", 32'(out_of(1)[8:0]), 32'h11);
        chk("held_valid", 32'(valid_b), 1);
        chk("stalled_no_xfer", 32'(obs_q.size()), 0);
        tick_wait(1);
        rdy_v[1] = 1'b1;
        tick_wait(1);
        rdy_v[1] = 1'b0;
        @(negedge clock);
        chk("valid_after_accept", 32'(valid_b), 0);
        chk("accept_count", 32'(obs_q.size()), 1);
        if (obs_q.size() > 0) chk("accepted_word", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        else void'(exp_q.pop_front());
        rdy_v[1] = 1'b1;
        tick_wait(2 * cpb[1]);
        @(negedge clock);
        chk("dropped_never_delivered", 32'(obs_q.size()), 0);
        obs_q.delete();

        // Line held low for 12 bit times: one break pulse, no word
        tick_wait(1);
        b0 = brk_cnt[1];
        rx_v[1] = 1'b0;
        tick_wait(12 * cpb[1]);
        rx_v[1] = 1'b1;
        tick_wait(2 * cpb[1]);
        @(negedge clock);
        chk("long_break_pulses", 32'(brk_cnt[1] - b0), 1);
        chk("long_break_no_word", 32'(obs_q.size()), 0);

        // Reset in the middle of bit 3 of 0xF0 while a previous word is still held
        tick_wait(1);
        rdy_v[1] = 1'b0;
        send_frame(1, 9'h77, 1'b0, 1'b1);
        tick_wait(cpb[1]);
        for (int i = 0; i < 4; i++) drive_bit(1, 1'b0, cpb[1]);
        tick_wait(cpb[1] / 2);
        rst = 1'b0;
        rx_v[1] = 1'b1;
        tick_wait(5);
        rst = 1'b1;
        tick_wait(2);
        @(negedge clock);
        chk("mid_frame_reset_outputs", 32'(out_of(1)), 0);
        chk("mid_frame_reset_idle", 32'(dut_b.state), 32'(uart_pkg::IDLE));
        tick_wait(1);
        rdy_v[1] = 1'b1;
        tick_wait(3 * cpb[1]);
        @(negedge clock);
        chk("post_reset_no_word", 32'(obs_q.size()), 0);
        obs_q.delete();
        tick_wait(1);
        send_and_check(1, 9'h5A, 1'b0, 1'b1);

        // Randomised frames on the three fast configurations
        for (int inst = 1; inst < 4; inst++) begin
            for (int n = 0; n < 10; n++) begin
                logic [8:0] d;
                logic       pb, s1;
                d  = 9'($urandom_range(0, 511));
                if ($urandom_range(0, 9) == 0) d = 9'd0;
                pb = 1'($urandom_range(0, 1));
                s1 = ($urandom_range(0, 7) != 0);
                send_and_check(inst, d, pb, s1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
